// File: rtl/knn_pkg.sv
// Shared types for the KNN query sequencer: FSM states, count widths
// and the k clamp used when a query is accepted.
package knn_pkg;

    localparam int KNN_NAME_W  = 32;
    localparam int KNN_COUNT_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_REF,
        STREAM,
        WAIT_DIST,
        FLUSH,
        SORT_WAIT,
        READOUT,
        FINISH
    } knn_state_e;

    function automatic logic [KNN_COUNT_W-1:0] clamp_k(
        input logic [KNN_COUNT_W-1:0] k_req,
        input logic [KNN_COUNT_W-1:0] k_max
    );
        return (k_req > k_max) ? k_max : k_req;
    endfunction

endpackage

// File: rtl/knn_sequencer_if.sv
// Control/stream bundle between the AXI-side logic, the sequencer
// and the KNN datapath.
interface knn_sequencer_if
    import knn_pkg::*;
#(
    parameter int DW = 32
);
    logic                   start;
    logic [KNN_COUNT_W-1:0] k;
    logic [KNN_COUNT_W-1:0] numPoints;
    logic                   s_valid;
    logic [DW-1:0]          s_data;
    logic                   s_ready;
    logic                   distanceValid;
    logic                   loadRef;
    logic [DW-1:0]          refDataOut;
    logic                   dataIn_Valid;
    logic [DW-1:0]          dataValueOut;
    logic [KNN_NAME_W-1:0]  dataNameOut;
    logic                   sortDone;
    logic                   resultValid;
    logic [KNN_COUNT_W-1:0] resultIndex;
    logic                   busy;
    logic                   finished;
    logic                   error;

    modport master (
        output start, k, numPoints, s_valid, s_data, distanceValid,
        input  s_ready, loadRef, refDataOut, dataIn_Valid,
        input  dataValueOut, dataNameOut, sortDone, resultValid,
        input  resultIndex, busy, finished, error
    );

    modport slave (
        input  start, k, numPoints, s_valid, s_data, distanceValid,
        output s_ready, loadRef, refDataOut, dataIn_Valid,
        output dataValueOut, dataNameOut, sortDone, resultValid,
        output resultIndex, busy, finished, error
    );

endinterface

// File: rtl/knn_dim_counter.sv
// Wrap-around counter with clear priority over enable and a
// terminal-count flag raised while the count equals max_i.
module knn_dim_counter
    import knn_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clr_i,
    input  logic                   en_i,
    input  logic [KNN_COUNT_W-1:0] max_i,
    output logic [KNN_COUNT_W-1:0] cnt_o,
    output logic                   tc_o
);

    logic [KNN_COUNT_W-1:0] cnt_q;
    logic [KNN_COUNT_W-1:0] cnt_d;

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == max_i);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tc_o ? '0 : cnt_q + KNN_COUNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/knn_sequencer.sv
// Sequences one KNN query: reference load, point streaming with one
// point in flight, sorter kick-off and framing of the k results.
module knn_sequencer
    import knn_pkg::*;
#(
    parameter int dataWidth          = 32,
    parameter int numberOfDimensions = 32,
    parameter int MAX_K              = 16,
    parameter int SORT_LATENCY       = 2
) (
    input  logic            clk,
    input  logic            reset,
    knn_sequencer_if.slave  bus
);

    localparam int CW = KNN_COUNT_W;
    localparam logic [CW-1:0] DIM_LAST = CW'(numberOfDimensions - 1);
    localparam logic [CW-1:0] K_LIMIT  = CW'(MAX_K);
    localparam logic [CW-1:0] SL_LAST  = CW'(SORT_LATENCY - 1);
    localparam logic [CW-1:0] SL_FULL  = CW'(SORT_LATENCY);

    knn_state_e state_q, state_d;

    logic [CW-1:0]         keff_q, keff_d;
    logic [CW-1:0]         npts_q, npts_d;
    logic [KNN_NAME_W-1:0] pidx_q, pidx_d;
    logic [CW-1:0]         wait_q, wait_d;
    logic                  err_q, err_d;

    logic                 load_q, load_d;
    logic [dataWidth-1:0] refd_q, refd_d;
    logic                 div_q, div_d;
    logic [dataWidth-1:0] dval_q, dval_d;

    logic          in_load, in_stream, s_ready;
    logic          hs, accept;
    logic          dim_tc, rd_tc;
    logic [CW-1:0] dim_idx_unused;
    logic [CW-1:0] rd_cnt;

    assign in_load   = (state_q == LOAD_REF);
    assign in_stream = (state_q == STREAM);
    assign s_ready   = in_load | in_stream;
    assign hs        = bus.s_valid & s_ready;

    // Reference words and point dimensions share one dimension counter
    knn_dim_counter u_dim_cnt (
        .clk   (clk),
        .reset (reset),
        .clr_i (accept),
        .en_i  (hs),
        .max_i (DIM_LAST),
        .cnt_o (dim_idx_unused),
        .tc_o  (dim_tc)
    );

    knn_dim_counter u_rd_cnt (
        .clk   (clk),
        .reset (reset),
        .clr_i (accept),
        .en_i  (state_q == READOUT),
        .max_i (keff_q - CW'(1)),
        .cnt_o (rd_cnt),
        .tc_o  (rd_tc)
    );

    always_comb begin
        state_d = state_q;
        keff_d  = keff_q;
        npts_d  = npts_q;
        pidx_d  = pidx_q;
        wait_d  = wait_q;
        err_d   = err_q;
        accept  = 1'b0;

        if (bus.distanceValid && state_q != WAIT_DIST) begin
            err_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    keff_d  = clamp_k(bus.k, K_LIMIT);
                    npts_d  = bus.numPoints;
                    pidx_d  = '0;
                    wait_d  = '0;
                    err_d   = 1'b0;
                    state_d = LOAD_REF;
                end
            end
            LOAD_REF: begin
                if (hs && dim_tc) begin
                    state_d = (npts_q == '0) ? FLUSH : STREAM;
                end
            end
            STREAM: begin
                if (hs && dim_tc) begin
                    state_d = WAIT_DIST;
                end
            end
            WAIT_DIST: begin
                if (bus.distanceValid) begin
                    pidx_d  = pidx_q + KNN_NAME_W'(1);
                    state_d = (pidx_q + 1 < npts_q) ? STREAM : FLUSH;
                end
            end
            FLUSH: begin
                wait_d  = '0;
                state_d = SORT_WAIT;
            end
            SORT_WAIT: begin
                wait_d = wait_q + CW'(1);
                // An empty result set still drains one slot past the latency
                if (keff_q == '0) begin
                    if (wait_q == SL_FULL) state_d = FINISH;
                end else if (wait_q == SL_LAST) begin
                    state_d = READOUT;
                end
            end
            READOUT: begin
                if (rd_tc) state_d = FINISH;
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign load_d = hs & in_load;
    assign refd_d = (hs & in_load) ? bus.s_data : refd_q;
    assign div_d  = hs & in_stream;
    assign dval_d = (hs & in_stream) ? bus.s_data : dval_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            keff_q  <= '0;
            npts_q  <= '0;
            pidx_q  <= '0;
            wait_q  <= '0;
            err_q   <= 1'b0;
            load_q  <= 1'b0;
            refd_q  <= '0;
            div_q   <= 1'b0;
            dval_q  <= '0;
        end else begin
            state_q <= state_d;
            keff_q  <= keff_d;
            npts_q  <= npts_d;
            pidx_q  <= pidx_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
            load_q  <= load_d;
            refd_q  <= refd_d;
            div_q   <= div_d;
            dval_q  <= dval_d;
        end
    end

    assign bus.s_ready      = s_ready;
    assign bus.loadRef      = load_q;
    assign bus.refDataOut   = refd_q;
    assign bus.dataIn_Valid = div_q;
    assign bus.dataValueOut = dval_q;
    assign bus.dataNameOut  = pidx_q;
    assign bus.sortDone     = (state_q == FLUSH);
    assign bus.resultValid  = (state_q == READOUT);
    assign bus.resultIndex  = (state_q == READOUT) ? rd_cnt : '0;
    assign bus.busy         = (state_q != IDLE);
    assign bus.finished     = (state_q == FINISH);
    assign bus.error        = err_q;

endmodule

// File: tb/tb_knn_sequencer.sv
// Directed bench for knn_sequencer: 4 dimensions, MAX_K 16, sort latency 2,
// with a small accumulator model answering 3 cycles after each point.
module tb_knn_sequencer;

    localparam int DW = 32;
    localparam int ND = 4;
    localparam int MK = 16;
    localparam int SL = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    knn_sequencer_if #(.DW(DW)) bus();

    knn_sequencer #(
        .dataWidth          (DW),
        .numberOfDimensions (ND),
        .MAX_K              (MK),
        .SORT_LATENCY       (SL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad = 0;

    logic dv_model = 1'b0;
    logic dv_tb = 1'b0;
    logic mon_clr = 1'b0;
    logic model_en = 1'b0;
    assign bus.distanceValid = dv_model | dv_tb;

    int cyc = 0;
    int n_load, n_div, n_sort, n_res, n_fin;
    int t_load, t_sort, t_res0, t_resl, t_fin, t_dv;
    int dim_seen, cd;
    logic [31:0] ref_q[$];
    logic [31:0] dat_q[$];
    logic [31:0] name_q[$];
    logic [31:0] res_q[$];

    // Pulse recorder plus accumulator model
    always @(negedge clk) begin
        cyc++;
        if (mon_clr) begin
            n_load = 0; n_div = 0; n_sort = 0; n_res = 0; n_fin = 0;
            t_load = 0; t_sort = 0; t_res0 = 0; t_resl = 0;
            t_fin = 0; t_dv = 0; dim_seen = 0; cd = 0;
            dv_model = 1'b0;
            ref_q.delete(); dat_q.delete();
            name_q.delete(); res_q.delete();
        end else begin
            if (bus.loadRef) begin
                n_load++; t_load = cyc;
                ref_q.push_back(bus.refDataOut);
            end
            if (bus.dataIn_Valid) begin
                n_div++;
                dat_q.push_back(bus.dataValueOut);
                name_q.push_back(bus.dataNameOut);
            end
            if (bus.sortDone) begin
                n_sort++; t_sort = cyc;
            end
            if (bus.resultValid) begin
                if (n_res == 0) t_res0 = cyc;
                n_res++; t_resl = cyc;
                res_q.push_back(bus.resultIndex);
            end
            if (bus.finished) begin
                n_fin++; t_fin = cyc;
            end
            dv_model = 1'b0;
            if (cd == 1) begin
                dv_model = 1'b1; t_dv = cyc; cd = 0;
            end else if (cd > 1) begin
                cd--;
            end
            if (model_en && bus.dataIn_Valid) begin
                dim_seen++;
                if (dim_seen == ND) begin
                    dim_seen = 0; cd = 3;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] flags();
        return {24'd0, bus.busy, bus.s_ready, bus.loadRef,
                bus.dataIn_Valid, bus.sortDone, bus.resultValid,
                bus.finished, bus.error};
    endfunction

    task automatic mon_clear();
        mon_clr = 1'b1;
        step();
        mon_clr = 1'b0;
    endtask

    task automatic do_start(input int kk, input int np);
        bus.start = 1'b1;
        bus.k = kk;
        bus.numPoints = np;
        step();
        bus.start = 1'b0;
        chk("start_busy", {31'd0, bus.busy}, 1);
        chk("start_sready", {31'd0, bus.s_ready}, 1);
    endtask

    task automatic send(input int n, input logic [31:0] base, input bit gaps);
        for (int i = 0; i < n; i++) begin
            int w;
            if (gaps) begin
                int g;
                g = $urandom_range(0, 2);
                repeat (g) step();
            end
            bus.s_valid = 1'b1;
            bus.s_data = base + i;
            w = 0;
            while (!bus.s_ready && w < 100) begin
                step();
                w++;
            end
            if (w >= 100) chk("s_ready_wait", {31'd0, bus.s_ready}, 1);
            step();
            bus.s_valid = 1'b0;
        end
    endtask

    task automatic wait_fin(input int budget);
        int n;
        n = 0;
        while (n_fin == 0 && n < budget) begin
            step();
            n++;
        end
        chk("finish_seen", n_fin, 1);
        chk("busy_after_fin", {31'd0, bus.busy}, 0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.k = '0;
        bus.numPoints = '0;
        bus.s_valid = 1'b0;
        bus.s_data = '0;

        // Reset and idle behaviour
        repeat (2) step();
        chk("rst_flags", flags(), 0);
        chk("rst_name", bus.dataNameOut, 0);
        reset = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_data = 32'hdead_beef;
        repeat (3) step();
        chk("idle_flags", flags(), 0);
        chk("idle_ridx", bus.resultIndex, 0);
        chk("idle_ref", bus.refDataOut, 0);
        bus.s_valid = 1'b0;

        // Three points, k=2
        mon_clear();
        model_en = 1'b1;
        do_start(2, 3);
        send(4, 32'h100, 1'b0);
        send(4, 32'h104, 1'b0);
        chk("t2_sready_drop", {31'd0, bus.s_ready}, 0);
        send(4, 32'h108, 1'b0);
        send(4, 32'h10c, 1'b0);
        wait_fin(100);
        chk("t2_loads", n_load, 4);
        for (int i = 0; i < 4; i++) chk("t2_ref", ref_q[i], 32'h100 + i);
        chk("t2_div", n_div, 12);
        for (int i = 0; i < 12; i++) begin
            chk("t2_data", dat_q[i], 32'h104 + i);
            chk("t2_name", name_q[i], i / 4);
        end
        chk("t2_sort", n_sort, 1);
        chk("t2_sort_lat", t_sort - t_dv, 1);
        chk("t2_nres", n_res, 2);
        chk("t2_res0", res_q[0], 0);
        chk("t2_res1", res_q[1], 1);
        chk("t2_res_lat", t_res0 - t_sort, SL + 1);
        chk("t2_fin_lat", t_fin - t_resl, 1);

        // No points, k=5, with an ignored start while busy
        mon_clear();
        model_en = 1'b0;
        do_start(5, 0);
        bus.start = 1'b1;
        bus.k = 9;
        step();
        bus.start = 1'b0;
        send(4, 32'h200, 1'b0);
        wait_fin(100);
        chk("t3_loads", n_load, 4);
        chk("t3_ref3", ref_q[3], 32'h203);
        chk("t3_div", n_div, 0);
        chk("t3_sort", n_sort, 1);
        chk("t3_sort_at", t_sort - t_load, 0);
        chk("t3_nres", n_res, 5);
        chk("t3_res4", res_q[4], 4);
        chk("t3_res_lat", t_res0 - t_sort, SL + 1);

        // k clamped to MAX_K
        mon_clear();
        do_start(40, 0);
        send(4, 32'h280, 1'b0);
        wait_fin(100);
        chk("t4_nres", n_res, MK);
        chk("t4_res15", res_q[15], 15);

        // k=0
        mon_clear();
        do_start(0, 0);
        send(4, 32'h2c0, 1'b0);
        wait_fin(100);
        chk("t5_nres", n_res, 0);
        chk("t5_sort", n_sort, 1);
        chk("t5_fin_lat", t_fin - t_sort, SL + 2);

        // Spurious distanceValid in STREAM
        mon_clear();
        model_en = 1'b1;
        do_start(1, 1);
        send(4, 32'h300, 1'b0);
        send(2, 32'h310, 1'b0);
        dv_tb = 1'b1;
        step();
        dv_tb = 1'b0;
        chk("t6_err", {31'd0, bus.error}, 1);
        chk("t6_name", bus.dataNameOut, 0);
        chk("t6_still_stream", {31'd0, bus.s_ready}, 1);
        send(2, 32'h312, 1'b0);
        wait_fin(100);
        chk("t6_err_sticky", {31'd0, bus.error}, 1);
        chk("t6_div", n_div, 4);
        chk("t6_name3", name_q[3], 0);
        chk("t6_nres", n_res, 1);

        // Reset mid-STREAM
        mon_clear();
        do_start(2, 2);
        chk("t7_err_clr", {31'd0, bus.error}, 0);
        send(4, 32'h400, 1'b0);
        send(2, 32'h410, 1'b0);
        reset = 1'b1;
        step();
        chk("t7_rst_flags", flags(), 0);
        chk("t7_rst_name", bus.dataNameOut, 0);
        chk("t7_rst_dval", bus.dataValueOut, 0);
        reset = 1'b0;
        repeat (5) step();
        chk("t7_no_sort", n_sort, 0);
        chk("t7_no_fin", n_fin, 0);
        chk("t7_idle_flags", flags(), 0);

        // New query with random s_valid gaps
        mon_clear();
        do_start(2, 2);
        send(12, 32'h500, 1'b1);
        wait_fin(300);
        chk("t8_loads", n_load, 4);
        for (int i = 0; i < 4; i++) chk("t8_ref", ref_q[i], 32'h500 + i);
        chk("t8_div", n_div, 8);
        for (int i = 0; i < 8; i++) begin
            chk("t8_data", dat_q[i], 32'h504 + i);
            chk("t8_name", name_q[i], i / 4);
        end
        chk("t8_nres", n_res, 2);
        chk("t8_sort", n_sort, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/knn_sequencer.md
# knn_sequencer

Controller that sequences one complete K-nearest-neighbour query through the KNN datapath: reference-FIFO load, distance accumulator and k-sorter. It takes one input word stream that carries the reference vector followed by every candidate point. It then drives `loadRef`, `dataIn_Valid`, the data word and the point name into the datapath, and pulses `done` to the sorter. Finally, it frames the k sorted results with a valid strobe. It sits between the AXI-side register/stream logic and the accelerator top.

## Interface
- `dataWidth`, 32: width of stream, reference and data words.
- `numberOfDimensions`, 32: words per point, minimum 2.
- `MAX_K`, 16: largest k; larger requests are clamped.
- `SORT_LATENCY`, 2: cycles from the sorter `done` pulse to the first valid result.

- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: query start; sampled only in IDLE.
- `k`  in  32: neighbour count; latched on accepted `start`.
- `numPoints`  in  32: candidate point count; latched on accepted `start`.
- `s_valid`  in  1: input word valid.
- `s_data`  in  dataWidth: input word.
- `s_ready`  out  1: input word ready.
- `distanceValid`  in  1: accumulator distance strobe.
- `loadRef`  out  1: reference word write to the FIFO.
- `refDataOut`  out  dataWidth: reference word.
- `dataIn_Valid`  out  1: data dimension valid to the FIFO and accumulator.
- `dataValueOut`  out  dataWidth: data dimension word.
- `dataNameOut`  out  32: index of the point whose distance is pending.
- `sortDone`  out  1: one-cycle pulse to the sorter `done` input.
- `resultValid`  out  1: sorter output carries a result.
- `resultIndex`  out  32: rank 0..k-1 of the current result.
- `busy`  out  1: query in progress.
- `finished`  out  1: one-cycle pulse at the end of a query.
- `error`  out  1: sticky protocol error; cleared by an accepted `start`.

## Operation
- States: IDLE, LOAD_REF, STREAM, WAIT_DIST, FLUSH, SORT_WAIT, READOUT, FINISH.
- IDLE:
  - `start` latches kEff = min(k, MAX_K) and numPoints, and clears `error`.
  - Next state is LOAD_REF.
- LOAD_REF:
  - `s_ready`=1; each handshake (`s_valid`&&`s_ready`) writes one reference word.
  - After `numberOfDimensions` words: go to FLUSH if numPoints=0, else go to STREAM.
- STREAM:
  - `s_ready`=1; each handshake forwards one dimension.
  - The dimension counter wraps at `numberOfDimensions`-1.
  - On the last dimension of a point: go to WAIT_DIST; `s_ready`=0 there.
  - Only one point is ever in flight.
- WAIT_DIST:
  - `distanceValid` increments pointIdx.
  - Next state is STREAM if pointIdx+1 < numPoints, else FLUSH.
- FLUSH: `sortDone`=1 for exactly one cycle; go to SORT_WAIT.
- SORT_WAIT:
  - Counts `SORT_LATENCY` cycles, then goes to READOUT.
  - Goes directly to FINISH if kEff=0.
- READOUT:
  - `resultValid`=1 for kEff consecutive cycles.
  - `resultIndex` steps 0..kEff-1; then go to FINISH.
- FINISH: `finished`=1 for one cycle; go to IDLE.
- `dataNameOut` = pointIdx. It is stable from the first dimension of a point through its `distanceValid`.
- `error` sets when `distanceValid` is seen outside WAIT_DIST; the strobe is otherwise ignored.
- `start` is ignored while `busy`=1.
- All counters are 32-bit unsigned and zero on query start.

## Timing
- Reset values: every output 0, state IDLE, all counters 0.
- `reset` mid-query aborts the query; no `sortDone` or `finished` is emitted.
- `start` sampled at cycle n → `busy`=1 and `s_ready`=1 at n+1.
- `loadRef`/`refDataOut` and `dataIn_Valid`/`dataValueOut` are registered: asserted the cycle after the handshake, for one cycle per word.
- `s_ready` drops in the cycle after the last word of a point is accepted; no extra word is ever taken.
- `distanceValid` in the same cycle as entry to WAIT_DIST is counted.
- `sortDone` is asserted 1 cycle after the final `distanceValid`, or after the final reference word when numPoints=0.
- First `resultValid` is `SORT_LATENCY`+1 cycles after `sortDone`.
- `busy` falls in the cycle after `finished`; `start` is accepted again in that cycle.

## Structure
- Shared package `knn_pkg`:
  - state enum;
  - `KNN_NAME_W`=32 and `KNN_COUNT_W`=32;
  - the clamp function for k.
- One sub-module, `knn_dim_counter`: a wrap-around counter with enable and clear, plus a terminal-count flag. It is instantiated for the dimension count and reused for the readout count.

## Test plan
- Reset, then idle with `s_valid`=1 → all outputs 0, `s_ready`=0, no state change.
- `numberOfDimensions`=4, numPoints=3, k=2, accumulator model with distanceValid 3 cycles after the last dimension:
  - 4 `loadRef` pulses and 12 `dataIn_Valid` pulses;
  - `dataNameOut` steps 0,1,2;
  - one `sortDone`, then 2 `resultValid` cycles with indices 0,1, then `finished`.
- numPoints=0, k=5 → 4 reference words, `sortDone`, 5 results, no `dataIn_Valid`.
- k=40 with `MAX_K`=16 → exactly 16 `resultValid` cycles.
- k=0 → no `resultValid`; `finished` is `SORT_LATENCY`+2 cycles after `sortDone`.
- Spurious `distanceValid` in STREAM → `error`=1 and pointIdx unchanged.
- `reset` asserted mid-STREAM → IDLE next cycle with all outputs 0; a new `start` completes normally.
- Random `s_valid` gaps → data forwarded in order with no loss or duplication.
